// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Front end for the coffee-machine FSM. Each of the four raw active-low
// push-buttons is synchronised into the clk domain, debounced by its own
// small FSM, and turned into:
//   - a one-cycle press pulse when a press is accepted, plus auto-repeat
//     pulses while held for the buttons enabled in REPEAT_MASK;
//   - a debounced held level.
//
// Ports
//   clk              in   1  system clock
//   reset            in   1  synchronous, active-high reset
//   buttonWaiting    in   1  raw button, active-low, asynchronous   (bit 0)
//   buttonLeft       in   1  raw button, active-low, asynchronous   (bit 1)
//   buttonRight      in   1  raw button, active-low, asynchronous   (bit 2)
//   buttonSelection  in   1  raw button, active-low, asynchronous   (bit 3)
//   pressPulse       out  4  one-cycle press / auto-repeat pulse per button
//   heldLevel        out  4  1 while the button is accepted as pressed
//   anyPress         out  1  OR of pressPulse, registered alongside it
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter logic [3:0]  REPEAT_MASK     = 4'b0110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       buttonWaiting,
  input  logic       buttonLeft,
  input  logic       buttonRight,
  input  logic       buttonSelection,
  output logic [3:0] pressPulse,
  output logic [3:0] heldLevel,
  output logic       anyPress
);

  localparam int NB = 4;

  // Counters are sized to hold their largest terminal value with one spare bit.
  localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int          CNT_W  = $clog2(DEBOUNCE_CYCLES - 1) + 1;
  localparam int          RCNT_W = $clog2(RMAX - 1) + 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RCNT_ZERO = {RCNT_W{1'b0}};
  localparam logic [RCNT_W-1:0] RCNT_ONE  = {{(RCNT_W-1){1'b0}}, 1'b1};
  localparam logic [RCNT_W-1:0] RD_MAX    = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RP_MAX    = RCNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_RELEASED        = 2'd0,
    ST_CONFIRM_PRESS   = 2'd1,
    ST_PRESSED         = 2'd2,
    ST_CONFIRM_RELEASE = 2'd3
  } state_t;

  logic [NB-1:0]     raw_s;
  logic [NB-1:0]     sync1_q, sync1_d;
  logic [NB-1:0]     sync2_q, sync2_d;
  state_t            state_q    [NB];
  state_t            state_d    [NB];
  logic [CNT_W-1:0]  cnt_q      [NB];
  logic [CNT_W-1:0]  cnt_d      [NB];
  logic [RCNT_W-1:0] rcnt_q     [NB];
  logic [RCNT_W-1:0] rcnt_d     [NB];
  logic [NB-1:0]     repeated_q, repeated_d;  // 1 once the first auto-repeat has fired
  logic [NB-1:0]     pulse_q, pulse_d;
  logic [NB-1:0]     held_q, held_d;
  logic              any_q, any_d;

  assign raw_s      = {buttonSelection, buttonRight, buttonLeft, buttonWaiting};
  assign pressPulse = pulse_q;
  assign heldLevel  = held_q;
  assign anyPress   = any_q;

  // Next-state logic: synchroniser shift plus four independent debounce/repeat FSMs.
  always_comb begin
    sync1_d    = raw_s;
    sync2_d    = sync1_q;
    repeated_d = repeated_q;
    pulse_d    = {NB{1'b0}};
    held_d     = {NB{1'b0}};
    for (int i = 0; i < NB; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      rcnt_d[i]  = rcnt_q[i];
      case (state_q[i])
        ST_RELEASED: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_CONFIRM_PRESS;
            cnt_d[i]   = CNT_ZERO;
          end else begin
            state_d[i] = ST_RELEASED;
          end
        end
        ST_CONFIRM_PRESS: begin
          if (sync2_q[i]) begin
            state_d[i] = ST_RELEASED;
            cnt_d[i]   = CNT_ZERO;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i]    = ST_PRESSED;
            rcnt_d[i]     = RCNT_ZERO;
            repeated_d[i] = 1'b0;
            pulse_d[i]    = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (sync2_q[i]) begin
            state_d[i] = ST_CONFIRM_RELEASE;
            cnt_d[i]   = CNT_ZERO;
          end else if (REPEAT_MASK[i]) begin
            // A repeat due right after another pulse (only possible with a
            // limit of 1 cycle) waits one cycle so pulses never run together.
            if (rcnt_q[i] >= (repeated_q[i] ? RP_MAX : RD_MAX)) begin
              if (!pulse_q[i]) begin
                pulse_d[i]    = 1'b1;
                rcnt_d[i]     = RCNT_ZERO;
                repeated_d[i] = 1'b1;
              end else begin
                rcnt_d[i] = rcnt_q[i];
              end
            end else begin
              rcnt_d[i] = rcnt_q[i] + RCNT_ONE;
            end
          end else begin
            rcnt_d[i] = rcnt_q[i];
          end
        end
        ST_CONFIRM_RELEASE: begin
          // A bounce back to low resumes PRESSED with rcnt untouched.
          if (!sync2_q[i]) begin
            state_d[i] = ST_PRESSED;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = ST_RELEASED;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_RELEASED;
          cnt_d[i]   = CNT_ZERO;
          rcnt_d[i]  = RCNT_ZERO;
        end
      endcase
      held_d[i] = (state_d[i] == ST_PRESSED) || (state_d[i] == ST_CONFIRM_RELEASE);
    end
    any_d = |pulse_d;
  end

  // State and output registers with synchronous reset to the released condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= {NB{1'b1}};
      sync2_q    <= {NB{1'b1}};
      repeated_q <= {NB{1'b0}};
      pulse_q    <= {NB{1'b0}};
      held_q     <= {NB{1'b0}};
      any_q      <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= ST_RELEASED;
        cnt_q[i]   <= CNT_ZERO;
        rcnt_q[i]  <= RCNT_ZERO;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      repeated_q <= repeated_d;
      pulse_q    <= pulse_d;
      held_q     <= held_d;
      any_q      <= any_d;
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
    end
  end

endmodule
